// File: rtl/replica_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : replica_pkg                                                |
// | Shared node-chain geometry plus ordering controller types.           |
// | Rev     : 1.0  initial ordering controller additions                 |
// +----------------------------------------------------------------------+
package replica_pkg;

  // Node register chain geometry
  localparam int node_num     = 8;
  localparam int node_log     = 3;
  localparam int city_div_log = 2;

  // Beat counter width; sized so node_num*(cmd_num+1) never wraps
  localparam int ORDERING_CNT_W = node_log + city_div_log + 1;

  typedef logic [7:0][7:0] ordering_word_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } ordering_ctrl_state_t;

  // Total beats for one command: node_num beats per node pass, cmd_num+1 passes
  function automatic logic [ORDERING_CNT_W-1:0] ordering_total(
    input logic [city_div_log-1:0] num
  );
    return ORDERING_CNT_W'(node_num) * (ORDERING_CNT_W'(num) + ORDERING_CNT_W'(1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ordering_rfifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ordering_rfifo                                              |
// | Synchronous read-return FIFO of ordering_word_t with occupancy.      |
// | Push while full is accepted only together with a pop.                |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module ordering_rfifo
  import replica_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  ordering_word_t         wdata_i,
  input  logic                   pop_i,
  output ordering_word_t         rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  ordering_word_t mem_q [DEPTH];
  logic [AW-1:0]  wptr_q;
  logic [AW-1:0]  rptr_q;
  logic [AW:0]    count_q;
  logic           do_push_w;
  logic           do_pop_w;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rptr_q];
  assign do_pop_w  = pop_i && !empty_o;
  assign do_push_w = push_i && (!full_o || do_pop_w);

  // Storage array; contents are don't-care until pointed at, so no reset
  always_ff @(posedge clk) begin
    if (do_push_w) mem_q[wptr_q] <= wdata_i;
  end

  // Pointers and occupancy; simultaneous push/pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push_w) wptr_q <= wptr_q + AW'(1);
      if (do_pop_w)  rptr_q <= rptr_q + AW'(1);
      case ({do_push_w, do_pop_w})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ordering_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ordering_ctrl                                               |
// | Moves host write/read streams to/from the node register chain.      |
// | Reads are credit-limited so the return FIFO can never overflow.     |
// | Optional: ORDERING_CTRL_TIMEOUT_EN adds a 16-bit stall watchdog     |
// |           and the sticky err output.                                 |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module ordering_ctrl
  import replica_pkg::*;
#(
  parameter int RD_LAT      = 2,
  parameter int RFIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [city_div_log-1:0] cmd_num,
  input  logic [63:0]             s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [63:0]             m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [city_div_log-1:0] ordering_num,
  output logic                    ordering_write,
  output logic                    ordering_read,
  output logic [63:0]             ordering_wdata,
  input  logic [63:0]             ordering_rdata,
  input  logic                    ordering_ready,
  output logic                    busy,
`ifdef ORDERING_CTRL_TIMEOUT_EN
  output logic                    err,
`endif
  output logic                    done
);

  localparam int CW = $clog2(RFIFO_DEPTH) + 1;

  ordering_ctrl_state_t        state_q, state_d;
  logic [ORDERING_CNT_W-1:0]   cnt_q, cnt_d;
  logic [city_div_log-1:0]     num_q, num_d;
  logic [RD_LAT-1:0]           pipe_q, pipe_d;

  logic                        beat_w;
  logic                        rd_issue_w;
  logic                        credit_w;
  logic                        timeout_w;
  logic [CW-1:0]               inflight_w;
  logic [CW:0]                 credit_sum_w;
  logic                        push_w;
  logic                        pop_w;
  ordering_word_t              fifo_rdata_w;
  logic                        fifo_full_w;
  logic                        fifo_empty_w;
  logic [CW-1:0]               fifo_count_w;

  // Handshake-visible outputs decoded straight from state
  assign cmd_ready      = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign ordering_num   = num_q;
  assign ordering_write = (state_q == ST_WRITE) && s_valid;
  assign s_ready        = (state_q == ST_WRITE) && ordering_ready;
  assign ordering_wdata = (state_q == ST_WRITE) ? s_data : 64'd0;
  assign ordering_read  = (state_q == ST_READ) && credit_w && (cnt_q != '0);

  assign rd_issue_w = ordering_read && ordering_ready;
  assign beat_w     = (ordering_write || ordering_read) && ordering_ready;

  // Read return path: pipe exit feeds the FIFO, FIFO head feeds the host
  assign push_w  = pipe_q[RD_LAT-1];
  assign m_valid = !fifo_empty_w;
  assign pop_w   = m_valid && m_ready;
  assign m_data  = fifo_empty_w ? 64'd0 : fifo_rdata_w;

  // Count beats still travelling through the latency pipe
  always_comb begin
    inflight_w = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_w = inflight_w + CW'(pipe_q[i]);
    end
  end

  // A read may issue only if every outstanding beat already owns a FIFO slot
  assign credit_sum_w = {1'b0, fifo_count_w} + {1'b0, inflight_w};
  assign credit_w     = (credit_sum_w < (CW+1)'(RFIFO_DEPTH));
  assign pipe_d       = RD_LAT'({pipe_q, rd_issue_w});

  ordering_rfifo #(
    .DEPTH (RFIFO_DEPTH)
  ) u_rfifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_w),
    .wdata_i (ordering_word_t'(ordering_rdata)),
    .pop_i   (pop_w),
    .rdata_o (fifo_rdata_w),
    .full_o  (fifo_full_w),
    .empty_o (fifo_empty_w),
    .count_o (fifo_count_w)
  );

`ifdef ORDERING_CTRL_TIMEOUT_EN
  logic [15:0] wd_q;
  logic        err_q;

  assign timeout_w = (wd_q == 16'hFFFF);
  assign err       = err_q;

  // Watchdog: counts stalled request cycles, cleared by any beat or leaving WRITE/READ
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q  <= 16'd0;
      err_q <= 1'b0;
    end else begin
      if (beat_w || !(state_q == ST_WRITE || state_q == ST_READ)) begin
        wd_q <= 16'd0;
      end else if ((ordering_write || ordering_read) && !timeout_w) begin
        wd_q <= wd_q + 16'd1;
      end
      if (timeout_w) err_q <= 1'b1;
    end
  end
`else
  assign timeout_w = 1'b0;
`endif

  // State, counter, latched command size and read pipe registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      pipe_q  <= pipe_d;
    end
  end

  // Next-state logic: beat accounting and phase sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = cmd_dir ? ST_READ : ST_WRITE;
          cnt_d   = ordering_total(cmd_num);
          num_d   = cmd_num;
        end
      end
      ST_WRITE, ST_READ: begin
        if (beat_w) cnt_d = cnt_q - ORDERING_CNT_W'(1);
        if (timeout_w) begin
          state_d = ST_DONE;
        end else if (beat_w && (cnt_q == ORDERING_CNT_W'(1))) begin
          state_d = (state_q == ST_WRITE) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((pipe_q == '0) && fifo_empty_w && !pop_w) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Credit accounting must keep the FIFO from being pushed while full without a pop
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push_w && fifo_full_w && !pop_w));

endmodule
`default_nettype wire

// File: tb/tb_ordering_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_ordering_ctrl                                            |
// | Scoreboard bench for ordering_ctrl: write/read bursts, credit limit, |
// | back-pressure, reset during drain, optional watchdog timeout.       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_ordering_ctrl;
  import replica_pkg::*;

  localparam int RD_LAT      = 2;
  localparam int RFIFO_DEPTH = 4;
  localparam int BOUND       = 300;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    cmd_valid, cmd_ready, cmd_dir;
  logic [city_div_log-1:0] cmd_num;
  logic [63:0]             s_data;
  logic                    s_valid, s_ready;
  logic [63:0]             m_data;
  logic                    m_valid, m_ready;
  logic [city_div_log-1:0] ordering_num;
  logic                    ordering_write, ordering_read;
  logic [63:0]             ordering_wdata, ordering_rdata;
  logic                    ordering_ready;
  logic                    busy, done;
`ifdef ORDERING_CTRL_TIMEOUT_EN
  logic                    err;
`endif

  always #5 clk = ~clk;

  ordering_ctrl #(
    .RD_LAT      (RD_LAT),
    .RFIFO_DEPTH (RFIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_dir        (cmd_dir),
    .cmd_num        (cmd_num),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .ordering_num   (ordering_num),
    .ordering_write (ordering_write),
    .ordering_read  (ordering_read),
    .ordering_wdata (ordering_wdata),
    .ordering_rdata (ordering_rdata),
    .ordering_ready (ordering_ready),
    .busy           (busy),
`ifdef ORDERING_CTRL_TIMEOUT_EN
    .err            (err),
`endif
    .done           (done)
  );

  typedef struct {
    int          due;
    logic [63:0] data;
  } resp_t;

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          issued = 0;
  int          wr_beats = 0;
  int          rd_beats = 0;
  int          done_cnt = 0;
  logic [63:0] wr_exp[$];
  logic [63:0] rd_exp[$];
  resp_t       resp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_total++;
    $display("FAIL %s: got %h expected no beat", name, act);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Chain responder for reads plus the scoreboard monitor
  always @(negedge clk) begin : p_mon
    logic [63:0] w;
    if (resp_q.size() != 0 && resp_q[0].due == cyc) begin
      ordering_rdata = resp_q[0].data;
      void'(resp_q.pop_front());
    end else begin
      ordering_rdata = 64'd0;
    end
    if (ordering_read && ordering_ready) begin
      w = 64'hD00D_0000_0000_0000 | 64'(issued) | (64'(issued) << 24);
      resp_q.push_back('{due: cyc + RD_LAT, data: w});
      rd_exp.push_back(w);
      issued++;
    end
    if (ordering_write && ordering_ready) begin
      wr_beats++;
      if (wr_exp.size() == 0) unexpected("wr_beat", ordering_wdata);
      else check("wr_beat", ordering_wdata, wr_exp.pop_front());
    end
    if (m_valid && m_ready) begin
      rd_beats++;
      if (rd_exp.size() == 0) unexpected("rd_beat", m_data);
      else check("rd_beat", m_data, rd_exp.pop_front());
    end
    if (done) done_cnt++;
  end

  task automatic send_cmd(input logic dir, input logic [city_div_log-1:0] num);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_num   = num;
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("ordering_num", ordering_num, num);
    check("busy_active", busy, 1);
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    @(negedge clk);
    while (!done && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    check(name, done, 1);
    @(posedge clk); #1;
  endtask

  task automatic write_burst(input int nbeats, input int stall_at, input int stall_len);
    int gaps = 0;
    int wb0  = wr_beats;
    int dc0  = done_cnt;
    ordering_ready = 1'b1;
    send_cmd(1'b0, city_div_log'(nbeats / node_num - 1));
    for (int i = 0; i < nbeats; i++) begin
      int t = 0;
      logic [63:0] w;
      w = 64'hA5A5_0000_0000_0000 | (64'(i) << 32) | 64'(stall_at + 100 * i);
      s_valid = 1'b1;
      s_data  = w;
      wr_exp.push_back(w);
      if (i == stall_at) begin
        ordering_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          @(negedge clk);
          check("stall_s_ready_low", s_ready, 0);
          @(posedge clk); #1;
        end
        ordering_ready = 1'b1;
      end
      @(negedge clk);
      while (!s_ready && t < BOUND) begin
        @(negedge clk);
        t++;
      end
      gaps += t;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_data  = 64'd0;
    @(negedge clk);
    check("write_done_pulse", done, 1);
    @(negedge clk);
    check("write_back_idle", cmd_ready, 1);
    check("write_gapless", gaps, 0);
    check("write_beat_total", wr_beats - wb0, nbeats);
    check("write_queue_empty", wr_exp.size(), 0);
    check("write_done_count", done_cnt - dc0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int t;
    int base;
    int rb0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_num = '0;
    s_data = 64'd0; s_valid = 1'b0; m_ready = 1'b0; ordering_ready = 1'b0;
    ordering_rdata = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_req", {ordering_write, ordering_read, s_ready}, 0);
    check("rst_wdata", ordering_wdata, 0);
    check("rst_num", ordering_num, 0);
`ifdef ORDERING_CTRL_TIMEOUT_EN
    check("rst_err", err, 0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;

    // 32 gapless write beats, then with a 5-cycle stall at beat 10
    write_burst(32, -1, 0);
    write_burst(32, 10, 5);

    // Read with host stalled: credit caps issue at FIFO depth
    m_ready = 1'b0; ordering_ready = 1'b1;
    base = issued; rb0 = rd_beats;
    send_cmd(1'b1, '0);
    repeat (15) @(posedge clk);
    #1;
    check("credit_issue_cap", issued - base, RFIFO_DEPTH);
    @(negedge clk);
    check("credit_read_low", ordering_read, 0);
    check("credit_m_valid", m_valid, 1);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_done("read_done");
    check("read_beat_total", rd_beats - rb0, node_num);
    check("read_queue_empty", rd_exp.size(), 0);

    // Two-pass read with irregular host and chain back-pressure
    rb0 = rd_beats;
    send_cmd(1'b1, city_div_log'(1));
    t = 0; n = 0;
    while (n == 0 && t < BOUND) begin
      m_ready        = (t % 3) != 0;
      ordering_ready = (t % 5) != 2;
      @(negedge clk);
      if (done) n = 1;
      @(posedge clk); #1;
      t++;
    end
    check("read2_done", n, 1);
    check("read2_beat_total", rd_beats - rb0, 2 * node_num);
    check("read2_queue_empty", rd_exp.size(), 0);
    ordering_ready = 1'b1;

    // Reset while draining with words still queued
    m_ready = 1'b1;
    send_cmd(1'b1, '0);
    n = 0; t = 0;
    while (n < node_num && t < BOUND) begin
      @(negedge clk);
      if (ordering_read && ordering_ready) n++;
      t++;
    end
    check("drain_all_issued", n, node_num);
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("drain_busy", busy, 1);
    check("drain_words_queued", m_valid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rd_exp.delete();
    resp_q.delete();
    @(negedge clk);
    check("rst_drain_m_valid", m_valid, 0);
    check("rst_drain_busy", busy, 0);
    check("rst_drain_cmd_ready", cmd_ready, 1);
    m_ready = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_valid) n++;
    end
    check("rst_drain_no_data", n, 0);
    @(posedge clk); #1;

`ifdef ORDERING_CTRL_TIMEOUT_EN
    // Chain never ready: watchdog must abort the write
    ordering_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 64'h0BAD_F00D_0000_0001;
    send_cmd(1'b0, '0);
    n = 0; t = 0;
    while (n == 0 && t < 70000) begin
      @(negedge clk);
      if (done) n = 1;
      t++;
    end
    check("timeout_done", n, 1);
    check("timeout_err", err, 1);
    s_valid = 1'b0;
    @(negedge clk);
    check("timeout_idle", cmd_ready, 1);
    check("timeout_err_sticky", err, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ordering_ctrl.md
ORDERING_CTRL -- requirements
Module: ordering_ctrl

Interface
REQ-001 SHALL have parameter RD_LAT, default 2: cycles from an accepted read beat (ordering_read & ordering_ready) to valid ordering_rdata.
REQ-002 SHALL have parameter RFIFO_DEPTH, default 4: read-return FIFO entries, power of two, at least RD_LAT+1.
REQ-003 clk  in  1  clock; all logic on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  command handshake; cmd_dir in 1 (0=write, 1=read); cmd_num in city_div_log, beats per node minus one.
REQ-006 s_data/s_valid/s_ready  in/in/out  64/1/1  host write stream, 8x8-bit word.
REQ-007 m_data/m_valid/m_ready  out/out/in  64/1/1  host read stream.
REQ-008 ordering_num  out  city_div_log  latched cmd_num.
REQ-009 ordering_write/ordering_read  out  1/1  beat requests to the node register chain.
REQ-010 ordering_wdata out 64; ordering_rdata in 64; ordering_ready in 1 (chain can accept a beat).
REQ-011 busy  out  1  state not IDLE; done  out  1  one-cycle completion pulse.
REQ-012 err  out  1  sticky timeout flag; present only with the macro in REQ-029.

Function
REQ-013 FSM states: IDLE, WRITE, READ, DRAIN, DONE; cmd_ready = (state==IDLE).
REQ-014 Command accept moves IDLE->WRITE (cmd_dir=0) or IDLE->READ (cmd_dir=1); latches ordering_num; loads beat counter total = node_num*(cmd_num+1).
REQ-015 WRITE: ordering_write = s_valid; ordering_wdata = s_data, combinational; s_ready = ordering_ready.
  - Beat transfers when s_valid & ordering_ready.
REQ-016 WRITE: after the last beat, state goes to DONE on the next cycle.
REQ-017 READ: ordering_read = 1 only when credit is available (FIFO occupancy + in-flight beats < RFIFO_DEPTH).
  - Beat issues when ordering_read & ordering_ready.
REQ-018 Each issued read beat enters an RD_LAT-deep valid shift pipe; at the pipe exit, ordering_rdata is pushed into the FIFO the same cycle.
REQ-019 After the last read beat issues, state goes to DRAIN; DRAIN goes to DONE when the pipe is empty, the FIFO is empty, and there is no m_valid&m_ready pending.
REQ-020 m_valid = FIFO not empty; m_data = FIFO head; pop on m_valid & m_ready.
  - Simultaneous push and pop on a full FIFO is legal; occupancy stays unchanged.
REQ-021 FIFO overflow SHALL never occur, by the credit rule; verification asserts this.
REQ-022 DONE lasts one cycle with done=1, then goes to IDLE.
REQ-023 Outside WRITE: ordering_write=0, s_ready=0. Outside READ: ordering_read=0.
REQ-024 cmd_num=0 yields exactly node_num beats.
  - Counter width is node_log+city_div_log+1; it does not wrap.
REQ-025 Order is preserved: m_data beats appear in issue order.

Reset
REQ-026 Reset returns the FSM to IDLE from any state.
  - Flushes the FIFO and the pipe; clears the counter, credits, err and ordering_num.
REQ-027 Outputs during and after reset: cmd_ready=1 (after release); m_data=0; every other output = 0.
REQ-028 Reset mid-transfer discards in-flight read data; no m_valid follows.

Configuration
REQ-029 Macro ORDERING_CTRL_TIMEOUT_EN defined: a 16-bit watchdog counts cycles in WRITE/READ with a request high and ordering_ready low.
  - At 0xFFFF it sets err=1 and forces the FSM to DONE, with remaining beats abandoned.
  - The watchdog clears on any transferred beat.
REQ-030 Macro undefined: no watchdog, no err port; the FSM waits indefinitely.

Structure
REQ-031 replica_pkg gains typedef ordering_word_t (logic [7:0][7:0]) and the ordering_ctrl_state_t enum; node_num, node_log and city_div_log are reused from it.
REQ-032 One sub-module, ordering_rfifo: synchronous FIFO of ordering_word_t, parameter DEPTH, with full, empty and count outputs.

Verification
REQ-033 Write, node_num=8, cmd_num=3, s_valid always 1, ordering_ready always 1 -> 32 consecutive ordering_write beats, then done one cycle later.
REQ-034 Write with ordering_ready low for 5 cycles at beat 10 -> s_ready low for those cycles, no beat lost or duplicated, 32 total.
REQ-035 Read, cmd_num=0, m_ready held 0 -> exactly RFIFO_DEPTH beats issue, then ordering_read=0; releasing m_ready returns 8 words in order, then done.
REQ-036 Reset asserted in DRAIN with 2 words queued -> m_valid=0, busy=0 next cycle, cmd_ready=1.
REQ-037 Build with ORDERING_CTRL_TIMEOUT_EN, ordering_ready stuck 0 -> after 65535 cycles err=1, done pulses, state returns to IDLE.
